// File: rtl/vector_reduce_unit.sv
// Purpose: serially folds an 8-lane vector into one scalar (SUM / MAXU / MINU / XOR) plus a saturated 8-bit copy.
// Latency: done_valid is high from the LANES-th rising edge, counting the accept edge as the first; one request per LANES+1 cycles.
// Backpressure: start_ready only in IDLE; the result is held in DONE until done_ready, and no request is queued meanwhile.
module vector_reduce_unit #(
   parameter int N     = 32,
   parameter int LANES = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start_valid,
   output logic                      start_ready,
   input  logic [LANES-1:0][N-1:0]   vec,
   input  logic [1:0]                op,
   output logic [N-1:0]              result,
   output logic [7:0]                result_imm,
   output logic                      sat,
   output logic                      done_valid,
   input  logic                      done_ready,
   output logic                      busy
);

   localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(LANES - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                    state, next_state;
   logic [LANES-1:0][N-1:0]   vbuf;
   logic [1:0]                op_q;
   logic [N-1:0]              acc;
   logic [N-1:0]              fold;
   logic [IW-1:0]             idx;
   logic                      accept;

   assign accept = (state == S_IDLE) && start_valid;

   // State register; reset discards any in-flight reduction.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   // Next-state: single-lane vectors skip RUN entirely.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: if (start_valid) next_state = (LANES == 1) ? S_DONE : S_RUN;
         S_RUN:  if (idx == LAST_IDX) next_state = S_DONE;
         S_DONE: if (done_ready) next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Fold the current buffered lane into the accumulator; ties keep acc.
   always_comb begin
      fold = acc;
      case (op_q)
         2'b00: fold = acc + vbuf[idx];
         2'b01: fold = (vbuf[idx] > acc) ? vbuf[idx] : acc;
         2'b10: fold = (vbuf[idx] < acc) ? vbuf[idx] : acc;
         default: fold = acc ^ vbuf[idx];
      endcase
   end

   // Datapath: snapshot the request on accept so later input changes are harmless.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc  <= '0;
         idx  <= '0;
         op_q <= 2'b00;
      end else if (accept) begin
         vbuf <= vec;
         op_q <= op;
         acc  <= vec[0];
         idx  <= IW'(1);
      end else if (state == S_RUN) begin
         acc  <= fold;
         idx  <= idx + 1'b1;
      end
   end

   // Outputs: everything result-related is gated to zero outside DONE.
   always_comb begin
      start_ready = (state == S_IDLE);
      busy        = (state != S_IDLE);
      done_valid  = 1'b0;
      result      = '0;
      sat         = 1'b0;
      result_imm  = 8'h00;
      if (state == S_DONE) begin
         done_valid = 1'b1;
         result     = acc;
         sat        = (acc > N'(255));
         result_imm = sat ? 8'hFF : acc[7:0];
      end
   end

endmodule

// File: tb/tb_vector_reduce_unit.sv
// Bench for vector_reduce_unit: directed corner cases followed by random requests against a reference model.
// Latency is counted in rising edges with the accept edge as the first.
// Inputs are driven and outputs sampled on the falling edge.
module tb_vector_reduce_unit;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start_valid;
   logic              start_ready;
   logic [7:0][31:0]  vec;
   logic [1:0]        op;
   logic [31:0]       result;
   logic [7:0]        result_imm;
   logic              sat;
   logic              done_valid;
   logic              done_ready;
   logic              busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vector_reduce_unit #(.N(32), .LANES(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .start_valid(start_valid), .start_ready(start_ready),
      .vec(vec), .op(op),
      .result(result), .result_imm(result_imm), .sat(sat),
      .done_valid(done_valid), .done_ready(done_ready), .busy(busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference reduction straight from the operator definitions.
   function automatic logic [31:0] model(input logic [7:0][31:0] v, input logic [1:0] o);
      logic [63:0] sum;
      logic [31:0] a;
      sum = 64'd0;
      for (int i = 0; i < 8; i++) sum = sum + {32'd0, v[i]};
      case (o)
         2'b00: a = sum[31:0];
         2'b01: begin a = 32'd0;          for (int i = 0; i < 8; i++) if (v[i] > a) a = v[i]; end
         2'b10: begin a = 32'hFFFF_FFFF;  for (int i = 0; i < 8; i++) if (v[i] < a) a = v[i]; end
         default: begin a = 32'd0;        for (int i = 0; i < 8; i++) a = a ^ v[i]; end
      endcase
      return a;
   endfunction

   // One complete request; optionally scrambles vec/op right after the accept edge.
   task automatic run_req(input string tag, input logic [7:0][31:0] v, input logic [1:0] o,
                          input logic [31:0] exp_res, input bit mutate);
      int cnt;
      logic [7:0] exp_imm;
      logic       exp_sat;
      exp_sat = (exp_res > 32'd255);
      exp_imm = exp_sat ? 8'hFF : exp_res[7:0];
      chk({tag, ".start_ready"}, {63'd0, start_ready}, 64'd1);
      vec = v; op = o; start_valid = 1'b1;
      @(posedge clk);
      cnt = 1;
      @(negedge clk);
      start_valid = 1'b0;
      if (mutate) begin
         vec = '1;
         op  = 2'b11;
      end
      while (!done_valid && cnt < 20) begin
         @(posedge clk);
         cnt++;
         @(negedge clk);
      end
      chk({tag, ".latency"},    64'(cnt),        64'd8);
      chk({tag, ".result"},     {32'd0, result}, {32'd0, exp_res});
      chk({tag, ".result_imm"}, {56'd0, result_imm}, {56'd0, exp_imm});
      chk({tag, ".sat"},        {63'd0, sat},    {63'd0, exp_sat});
      done_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      done_ready = 1'b0;
      chk({tag, ".done_clear"}, {63'd0, done_valid}, 64'd0);
   endtask

   initial begin
      logic [7:0][31:0] v;
      logic [31:0]      held;
      logic [1:0]       o;
      int               cnt;

      rst_n = 1'b0; start_valid = 1'b0; done_ready = 1'b0; vec = '0; op = 2'b00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst.start_ready", {63'd0, start_ready}, 64'd1);
      chk("rst.done_valid",  {63'd0, done_valid},  64'd0);
      chk("rst.busy",        {63'd0, busy},        64'd0);
      chk("rst.result",      {32'd0, result},      64'd0);
      chk("rst.result_imm",  {56'd0, result_imm},  64'd0);
      chk("rst.sat",         {63'd0, sat},         64'd0);

      // SUM of 1..8
      for (int i = 0; i < 8; i++) v[i] = 32'(i + 1);
      run_req("sum18", v, 2'b00, 32'd36, 1'b0);

      // MAXU / MINU with an all-ones lane
      v = '0; v[0] = 32'd5; v[1] = 32'hFFFF_FFFF; v[2] = 32'd7;
      run_req("maxu", v, 2'b01, 32'hFFFF_FFFF, 1'b0);
      run_req("minu", v, 2'b10, 32'd0, 1'b0);

      // SUM wrap and XOR
      for (int i = 0; i < 8; i++) v[i] = 32'h8000_0000;
      run_req("sumwrap", v, 2'b00, 32'd0, 1'b0);
      v = '0; v[0] = 32'hF0; v[1] = 32'h0F;
      run_req("xor", v, 2'b11, 32'hFF, 1'b0);

      // Backpressure with stray start pulses
      for (int i = 0; i < 8; i++) v[i] = 32'(i + 1);
      vec = v; op = 2'b00; start_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_valid = 1'b0;
      vec = '1; op = 2'b01;
      cnt = 1;
      while (!done_valid && cnt < 20) begin
         start_valid = cnt[0];
         @(posedge clk);
         cnt++;
         @(negedge clk);
      end
      chk("bp.latency", 64'(cnt), 64'd8);
      held = result;
      chk("bp.result", {32'd0, held}, 64'd36);
      for (int k = 0; k < 5; k++) begin
         start_valid = 1'b1;
         @(posedge clk);
         @(negedge clk);
         chk("bp.hold_result", {32'd0, result}, {32'd0, held});
         chk("bp.hold_valid",  {63'd0, done_valid}, 64'd1);
         chk("bp.start_ready", {63'd0, start_ready}, 64'd0);
      end
      done_ready = 1'b1; start_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      done_ready = 1'b0; start_valid = 1'b0;
      chk("bp.release_idle", {63'd0, start_ready}, 64'd1);
      chk("bp.release_busy", {63'd0, busy}, 64'd0);
      v = '0; v[3] = 32'd300;
      run_req("bp.next", v, 2'b00, 32'd300, 1'b0);

      // Reset in RUN at idx=4
      for (int i = 0; i < 8; i++) v[i] = 32'(i + 1);
      vec = v; op = 2'b00; start_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rr.busy_before", {63'd0, busy}, 64'd1);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("rr.done_valid",  {63'd0, done_valid},  64'd0);
      chk("rr.start_ready", {63'd0, start_ready}, 64'd1);
      chk("rr.busy",        {63'd0, busy},        64'd0);
      chk("rr.result",      {32'd0, result},      64'd0);
      run_req("rr.after", v, 2'b00, 32'd36, 1'b0);

      // Inputs scrambled after accept
      run_req("mutate", v, 2'b00, 32'd36, 1'b1);

      // Random requests against the model
      for (int n = 0; n < 24; n++) begin
         for (int i = 0; i < 8; i++) v[i] = $urandom >> $urandom_range(0, 31);
         o = 2'($urandom_range(0, 3));
         run_req($sformatf("rnd%0d", n), v, o, model(v, o), 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
